mult_iter_unit: RTL and testbench
=================================

# mult_iter_unit

- Iterative shift-and-add multiplier for MIPS `mult`/`multu`, producing the 64-bit HI/LO product.
- Sits downstream of the 8-bit carry-lookahead adder stages and consumes their sums.
- One partial-product addition per cycle through a WIDTH-bit adder built from WIDTH/8 cascaded 8-bit carry-lookahead stages.
- Start/busy/done handshake toward the pipeline control.

## Interface
- WIDTH, 32, operand width; must be a multiple of 8 and ≥ 8.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- is_signed  in  1  1 = signed multiply (`mult`), 0 = unsigned (`multu`).
- a  in  WIDTH  multiplicand, sampled with start.
- b  in  WIDTH  multiplier, sampled with start.
- busy  out  1  high in RUN, NEG_LO and NEG_HI.
- done  out  1  one-cycle pulse; hi/lo valid.
- hi  out  WIDTH  upper product half, registered.
- lo  out  WIDTH  lower product half, registered.

## Operation
- Reset values: state IDLE, busy 0, done 0, hi 0, lo 0, all internal registers 0.
- States: IDLE, RUN, NEG_LO, NEG_HI, DONE.
- Start accepted (IDLE or DONE, start=1):
  - Latch mcand and mplier.
  - Signed: latch |a| and |b|, and neg = a[MSB]^b[MSB]. Both are magnitudes modulo 2^WIDTH, so 0x80000000 becomes 2^31 unsigned.
  - Unsigned: latch a and b, neg = 0.
  - Clear acc_hi; load acc_lo = mplier; count = WIDTH; go to RUN.
- RUN, each cycle:
  - If acc_lo[0]=1: {c, s} = acc_hi + mcand (carry-in 0). Otherwise {c, s} = {0, acc_hi}.
  - {acc_hi, acc_lo} ← {c, s, acc_lo[WIDTH-1:1]}.
  - count decrements. On the cycle count reaches 0, go to NEG_LO if neg=1, otherwise DONE.
- NEG_LO: adder computes ~acc_lo + 1; store the sum into acc_lo and the carry into a 1-bit register.
- NEG_HI: adder computes ~acc_hi + stored carry; store into acc_hi; go to DONE.
- Entering DONE: hi ← acc_hi, lo ← acc_lo, done=1 for that single cycle.
- DONE: if start=1, accept the new operation (back-to-back). Otherwise go to IDLE.
- hi/lo hold their value from DONE until the next DONE or reset. They never show intermediate values.
- start while busy=1 is ignored, with no effect on state or outputs.
- rst mid-operation: asynchronously return to reset values. The partial result is discarded.

## Timing
- E0 is the edge that accepts start.
- Unsigned, or signed with neg=0:
  - busy=1 after E0, through the cycle ending at E(WIDTH).
  - done=1 in the cycle after E(WIDTH), so latency is WIDTH cycles.
- Signed with neg=1: done=1 after E(WIDTH+2), so latency is WIDTH+2 cycles.
- A zero product with neg=1 still takes WIDTH+2 cycles; negating 0 yields 0.
- Back-to-back: start high during the done cycle means the next done arrives exactly one latency later, with no idle gap.
- Critical path: one WIDTH-bit ripple of 8-bit carry-lookahead groups plus the shift mux. No multi-cycle paths.

## Configuration
- MULT_SIGNED_EN defined:
  - is_signed honoured.
  - Magnitude conversion, NEG_LO and NEG_HI are present.
- MULT_SIGNED_EN undefined:
  - is_signed is ignored; every operation is unsigned with neg=0.
  - NEG_LO/NEG_HI and the magnitude logic are not generated.
  - Latency is always WIDTH.

## Test plan
- Reset: assert rst mid-RUN at cycle 10 → busy=0, done=0, hi=lo=0 immediately. Then a new start with 7×6 unsigned → lo=0x0000002A, hi=0 after 32 cycles.
- Unsigned 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 32 cycles after E0, single-cycle pulse.
- Signed (MULT_SIGNED_EN) 0xFFFFFFFD×0x00000005 → hi=0xFFFFFFFF, lo=0xFFFFFFF1 at 34 cycles. Same stimulus without the macro → hi=0x00000004, lo=0xFFFFFFF1 at 32 cycles.
- Signed 0x80000000×0x80000000 → hi=0x40000000, lo=0x00000000 at 32 cycles. Signed 0x00000000×0xFFFFFFFE → hi=lo=0 at 34 cycles.
- start pulsed during RUN is ignored, and hi/lo are unchanged until done. start held during the done cycle with 3×4 unsigned → second done 32 cycles later with lo=0x0000000C.

Source files
------------

// File: rtl/mult_iter_unit.sv
// Iterative shift-and-add multiplier for mult/multu; one add per cycle through a chained 8-bit CLA adder.
// Latency WIDTH cycles (WIDTH+2 for negative signed products); start ignored while busy. Signed support via MULT_SIGNED_EN.
module mult_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int NG = WIDTH / 8;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_NEG_LO, S_NEG_HI, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
`ifdef MULT_SIGNED_EN
    logic             neg_q, neg_d;
    logic             cy_q, cy_d;
`else
    logic             unused_is_signed;
    assign unused_is_signed = is_signed;
`endif

    logic [WIDTH-1:0] add_a, add_b, add_s;
    logic             add_cin, add_co;

    // 8-bit group: every carry is formed from generate/propagate terms and the group carry-in directly.
    function automatic logic [8:0] cla8(input logic [7:0] x, input logic [7:0] y, input logic ci);
        logic [7:0] g, p;
        logic [8:0] c;
        logic       gg, pp;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < 8; i++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int j = 0; j <= i; j++) begin
                gg = g[j] | (p[j] & gg);
                pp = pp & p[j];
            end
            c[i+1] = gg | (pp & ci);
        end
        return {c[8], p ^ c[7:0]};
    endfunction

    always_comb begin
        add_a   = acc_hi_q;
        add_b   = acc_lo_q[0] ? mcand_q : '0;
        add_cin = 1'b0;
`ifdef MULT_SIGNED_EN
        if (state_q == S_NEG_LO) begin
            add_a   = ~acc_lo_q;
            add_b   = '0;
            add_cin = 1'b1;
        end else if (state_q == S_NEG_HI) begin
            add_a   = ~acc_hi_q;
            add_b   = '0;
            add_cin = cy_q;
        end
`endif
    end

    always_comb begin
        logic       gc;
        logic [8:0] r;
        add_s = '0;
        gc    = add_cin;
        r     = '0;
        for (int g = 0; g < NG; g++) begin
            r              = cla8(add_a[g*8 +: 8], add_b[g*8 +: 8], gc);
            add_s[g*8 +: 8] = r[7:0];
            gc             = r[8];
        end
        add_co = gc;
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MULT_SIGNED_EN
        neg_d    = neg_q;
        cy_d     = cy_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
`ifdef MULT_SIGNED_EN
                    mcand_d  = (is_signed && a[WIDTH-1]) ? -a : a;
                    acc_lo_d = (is_signed && b[WIDTH-1]) ? -b : b;
                    neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
                    mcand_d  = a;
                    acc_lo_d = b;
`endif
                    acc_hi_d = '0;
                    count_d  = CW'(WIDTH);
                    state_d  = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_hi_d = {add_co, add_s[WIDTH-1:1]};
                acc_lo_d = {add_s[0], acc_lo_q[WIDTH-1:1]};
                count_d  = count_q - CW'(1);
                if (count_q == CW'(1)) begin
`ifdef MULT_SIGNED_EN
                    if (neg_q) begin
                        state_d = S_NEG_LO;
                    end else begin
                        state_d = S_DONE;
                        hi_d    = acc_hi_d;
                        lo_d    = acc_lo_d;
                    end
`else
                    state_d = S_DONE;
                    hi_d    = acc_hi_d;
                    lo_d    = acc_lo_d;
`endif
                end
            end
`ifdef MULT_SIGNED_EN
            S_NEG_LO: begin
                acc_lo_d = add_s;
                cy_d     = add_co;
                state_d  = S_NEG_HI;
            end
            S_NEG_HI: begin
                acc_hi_d = add_s;
                hi_d     = add_s;
                lo_d     = acc_lo_q;
                state_d  = S_DONE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MULT_SIGNED_EN
            neg_q    <= 1'b0;
            cy_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MULT_SIGNED_EN
            neg_q    <= neg_d;
            cy_q     <= cy_d;
`endif
        end
    end

    assign busy = (state_q == S_RUN) || (state_q == S_NEG_LO) || (state_q == S_NEG_HI);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mult_iter_unit.sv
// Scoreboard bench for mult_iter_unit: driver pushes hand-computed products, monitor checks them on done.
module tb_mult_iter_unit;
`ifdef MULT_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, is_signed;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    mult_iter_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          e0;
        int          lat;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          cnt = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;
    logic [31:0] save_hi, save_lo;
    logic        pulse_chk = 1'b0;

    always @(posedge clk) cnt <= cnt + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Caller is at a negedge; E0 is the next rising edge.
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic sg,
                         input logic [31:0] ehi, input logic [31:0] elo, input int lat, input string nm);
        exp_t e;
        a = ia; b = ib; is_signed = sg; start = 1'b1;
        e.hi = ehi; e.lo = elo; e.e0 = cnt + 1; e.lat = lat; e.name = nm;
        sb_q.push_back(e);
        last_hi = ehi; last_lo = elo;
        @(negedge clk);
        start = 1'b0;
        check({nm, "_busy"}, 64'(busy), 64'd1);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        if (i == 200) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (pulse_chk) begin
                check("done_pulse_width", 64'(done), 64'd0);
                pulse_chk = 1'b0;
            end
            if (done) begin
                pulse_chk = 1'b1;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: got done=1 expected no result");
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                    check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                    check({e.name, "_latency"}, 64'(cnt - e.e0), 64'(e.lat));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int i;
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Operation aborted by reset mid-RUN; its result must never appear.
        a = 32'h1234_5678; b = 32'h0000_0005; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy", 64'(busy), 64'd1);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op(32'd7, 32'd6, 1'b0, 32'h0, 32'h0000_002A, 32, "u7x6");
        drain();
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 32, "umax");
        drain();
        do_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, SGN ? 32'hFFFF_FFFF : 32'h0000_0004,
              32'hFFFF_FFF1, SGN ? 34 : 32, "sm3x5");
        drain();
        do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0, 32, "smin2");
        drain();
        do_op(32'h0000_0000, 32'hFFFF_FFFE, 1'b1, 32'h0, 32'h0, SGN ? 34 : 32, "szero");
        drain();
        do_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, SGN ? 32'hFFFF_FFFF : 32'h0000_0001,
              32'hFFFF_FFFE, SGN ? 34 : 32, "sm1x2");
        drain();
        do_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, SGN ? 32'hC000_0000 : 32'h3FFF_FFFF,
              32'h8000_0000, SGN ? 34 : 32, "smaxmin");
        drain();

        // start pulsed mid-RUN must not disturb the operation or the held result.
        save_hi = last_hi; save_lo = last_lo;
        do_op(32'd9, 32'd9, 1'b0, 32'h0, 32'h0000_0051, 32, "u9x9");
        repeat (4) @(negedge clk);
        a = '1; b = '1; is_signed = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy", 64'(busy), 64'd1);
        check("ign_hold_hi", 64'(hi), 64'(save_hi));
        check("ign_hold_lo", 64'(lo), 64'(save_lo));
        repeat (10) @(negedge clk);
        check("ign_hold_lo_late", 64'(lo), 64'(save_lo));

        // Back-to-back: start held during the done cycle.
        for (i = 0; i < 60; i++) begin
            if (done) break;
            @(negedge clk);
        end
        if (i == 60) begin
            n_checks++;
            $display("FAIL b2b_wait_done: got no done within 60 cycles, expected done");
        end
        do_op(32'd3, 32'd4, 1'b0, 32'h0, 32'h0000_000C, 32, "b2b3x4");
        drain();
        repeat (2) @(negedge clk);
        check("final_idle_busy", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
